// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: CPU bus, UART TX/RX and status signals.
// master = CPU/UART side, slave = cpu_mem_responder.
interface cpu_mem_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_done;

  modport master (
    output mem_a, mem_wr, mem_dout,
    output tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full,
    input  tx_data, tx_valid,
    input  rx_ready, prog_done
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout,
    input  tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full,
    output tx_data, tx_valid,
    output rx_ready, prog_done
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: RAM + UART/TX FIFO + cycle counter I/O for a CPU.
// Ports: clk_in, rst_in (async low), bus (cpu_mem_responder_if.slave).
// Option: `define RESP_CYCLE_COUNTER_EN adds counter at 0x30004-7.
module cpu_mem_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  cpu_mem_responder_if.slave  bus
);

  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(TX_DEPTH - 1);

  logic [7:0] ram [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] ram_addr;

  logic        is_io;
  logic [15:0] io_off;
  logic        io_rd;
  logic        io_wr;
  logic        hit_rx;
  logic        hit_c0;
  logic        hit_c1;
  logic        hit_c2;
  logic        hit_c3;

  assign ram_addr = bus.mem_a[RAM_ADDR_W-1:0];
  assign is_io    = bus.mem_a[17:16] == 2'b11;
  assign io_off   = bus.mem_a[15:0];
  assign io_rd    = is_io & ~bus.mem_wr;
  assign io_wr    = is_io & bus.mem_wr;
  assign hit_rx   = io_off == 16'h0000;
  assign hit_c0   = io_off == 16'h0004;
  assign hit_c1   = io_off == 16'h0005;
  assign hit_c2   = io_off == 16'h0006;
  assign hit_c3   = io_off == 16'h0007;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.mem_a[31:18];

  logic [7:0] fifo_mem [TX_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push_req;
  logic [7:0]    push_byte;
  logic          push;
  logic          pop;

  assign bus.tx_valid = count != '0;
  assign bus.tx_data  = fifo_mem[rp];
  assign pop          = bus.tx_valid & bus.tx_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push = push_req & ((count != DEPTH_C) | pop);

  always_comb begin
    push_req  = 1'b0;
    push_byte = bus.mem_dout;
    if (io_wr && hit_rx && bus.mem_dout != 8'h00) begin
      push_req = 1'b1;
    end
    if (io_wr && hit_c0) begin
      push_req  = 1'b1;
      push_byte = 8'h00;
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + 1'b1;
    if (pop && !push) count_nxt = count - 1'b1;
  end

  logic [7:0] ctr_byte;

`ifdef RESP_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt;
  logic [31:0] snap;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cyc_cnt <= '0;
      snap    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (io_rd && hit_c0) snap <= cyc_cnt;
    end
  end

  // Byte 0 returns the live count being captured this cycle.
  always_comb begin
    ctr_byte = 8'h00;
    unique case (1'b1)
      hit_c0:  ctr_byte = cyc_cnt[7:0];
      hit_c1:  ctr_byte = snap[15:8];
      hit_c2:  ctr_byte = snap[23:16];
      hit_c3:  ctr_byte = snap[31:24];
      default: ctr_byte = 8'h00;
    endcase
  end
`else
  logic unused_ctr;
  assign unused_ctr = hit_c1 ^ hit_c2 ^ hit_c3;
  assign ctr_byte   = 8'h00;
`endif

  logic [7:0] io_rdata;

  always_comb begin
    io_rdata = ctr_byte;
    if (hit_rx) begin
      io_rdata = bus.rx_valid ? bus.rx_data : 8'h00;
    end
  end

  always_ff @(posedge clk_in) begin
    if (bus.mem_wr && !is_io) ram[ram_addr] <= bus.mem_dout;
    if (push) fifo_mem[wp] <= push_byte;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.mem_din        <= 8'h00;
      bus.rx_ready       <= 1'b0;
      bus.prog_done      <= 1'b0;
      bus.io_buffer_full <= 1'b0;
      wp                 <= '0;
      rp                 <= '0;
      count              <= '0;
    end else begin
      if (io_rd) bus.mem_din <= io_rdata;
      else if (is_io) bus.mem_din <= 8'h00;
      else bus.mem_din <= ram[ram_addr];
      bus.rx_ready <= io_rd & hit_rx & bus.rx_valid;
      if (io_wr && hit_c0) bus.prog_done <= 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count_nxt;
      bus.io_buffer_full <= count_nxt >= ALMOST;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed checks of RAM, TX FIFO, RX and counter.
// Expected values are hand-computed constants.
module tb_cpu_mem_responder;

  localparam logic [31:0] IDLE = 32'h0003_0010;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  cpu_mem_responder_if bus ();

  cpu_mem_responder #(
    .RAM_ADDR_W (17),
    .TX_DEPTH   (4)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr_cyc(logic [31:0] a, logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_wr   = 1'b1;
    bus.mem_dout = d;
    @(negedge clk_in);
  endtask

  task automatic rd_cyc(logic [31:0] a);
    bus.mem_a  = a;
    bus.mem_wr = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    bus.mem_a    = IDLE;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
    bus.tx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_din", bus.mem_din, 0);
    check("rst_txv", bus.tx_valid, 0);
    check("rst_rxr", bus.rx_ready, 0);
    check("rst_full", bus.io_buffer_full, 0);
    check("rst_done", bus.prog_done, 0);
    rst_in = 1'b1;
    rd_cyc(IDLE);

    // RAM write then read-back
    wr_cyc(32'h0000_0010, 8'hA5);
    rd_cyc(32'h0000_0010);
    check("ram_a5", bus.mem_din, 8'hA5);
    wr_cyc(32'h0001_FFFF, 8'h3C);
    wr_cyc(32'h0000_0011, 8'h5A);
    rd_cyc(32'h0001_FFFF);
    check("ram_top", bus.mem_din, 8'h3C);
    rd_cyc(32'h0000_0011);
    check("ram_11", bus.mem_din, 8'h5A);
    rd_cyc(IDLE);
    check("io_other", bus.mem_din, 0);

    // TX: zero byte dropped, almost-full at 3
    wr_cyc(32'h0003_0008, 8'h12);
    rd_cyc(IDLE);
    check("io_ign", bus.tx_valid, 0);
    wr_cyc(32'h0003_0000, 8'h41);
    wr_cyc(32'h0003_0000, 8'h00);
    wr_cyc(32'h0003_0000, 8'h42);
    wr_cyc(32'h0003_0000, 8'h43);
    rd_cyc(IDLE);
    check("tx_full3", bus.io_buffer_full, 1);
    check("tx_v", bus.tx_valid, 1);
    check("tx_41", bus.tx_data, 8'h41);
    bus.tx_ready = 1'b1;
    rd_cyc(IDLE);
    check("tx_42", bus.tx_data, 8'h42);
    check("tx_nfull", bus.io_buffer_full, 0);
    rd_cyc(IDLE);
    check("tx_43", bus.tx_data, 8'h43);
    rd_cyc(IDLE);
    check("tx_empty", bus.tx_valid, 0);
    bus.tx_ready = 1'b0;

    // Full FIFO: push blocked, then push+pop together
    wr_cyc(32'h0003_0000, 8'h01);
    wr_cyc(32'h0003_0000, 8'h02);
    wr_cyc(32'h0003_0000, 8'h03);
    wr_cyc(32'h0003_0000, 8'h04);
    check("ff_full", bus.io_buffer_full, 1);
    wr_cyc(32'h0003_0000, 8'h66);
    check("ff_head", bus.tx_data, 8'h01);
    bus.tx_ready = 1'b1;
    wr_cyc(32'h0003_0000, 8'h55);
    check("ff_keep", bus.io_buffer_full, 1);
    check("ff_02", bus.tx_data, 8'h02);
    rd_cyc(IDLE);
    check("ff_03", bus.tx_data, 8'h03);
    rd_cyc(IDLE);
    check("ff_04", bus.tx_data, 8'h04);
    rd_cyc(IDLE);
    check("ff_55", bus.tx_data, 8'h55);
    rd_cyc(IDLE);
    check("ff_empty", bus.tx_valid, 0);
    bus.tx_ready = 1'b0;

    // RX
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h37;
    rd_cyc(32'h0003_0000);
    check("rx_37", bus.mem_din, 8'h37);
    check("rx_rdy", bus.rx_ready, 1);
    bus.rx_valid = 1'b0;
    rd_cyc(IDLE);
    check("rx_pulse", bus.rx_ready, 0);
    rd_cyc(32'h0003_0000);
    check("rx_none", bus.mem_din, 0);
    check("rx_nordy", bus.rx_ready, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h11;
    rd_cyc(32'h0003_0000);
    check("rx_rep1", bus.rx_ready, 1);
    bus.rx_data  = 8'h22;
    rd_cyc(32'h0003_0000);
    check("rx_rep2", bus.rx_ready, 1);
    check("rx_22", bus.mem_din, 8'h22);
    bus.rx_valid = 1'b0;
    rd_cyc(IDLE);

    // Cycle counter bytes
`ifdef RESP_CYCLE_COUNTER_EN
    force dut.cyc_cnt = 32'hFFFF_FFFE;
    rd_cyc(32'h0003_0004);
    release dut.cyc_cnt;
    check("cc_b0", bus.mem_din, 8'hFE);
    rd_cyc(32'h0003_0005);
    check("cc_b1", bus.mem_din, 8'hFF);
    rd_cyc(32'h0003_0006);
    check("cc_b2", bus.mem_din, 8'hFF);
    rd_cyc(32'h0003_0007);
    check("cc_b3", bus.mem_din, 8'hFF);
    rd_cyc(IDLE);
    rd_cyc(32'h0003_0004);
    check("cc_wrap", bus.mem_din < 8'h10, 1);
    rd_cyc(32'h0003_0007);
    check("cc_wrap3", bus.mem_din, 8'h00);
`else
    rd_cyc(32'h0003_0004);
    check("cc_b0", bus.mem_din, 8'h00);
    rd_cyc(32'h0003_0005);
    check("cc_b1", bus.mem_din, 8'h00);
    rd_cyc(32'h0003_0006);
    check("cc_b2", bus.mem_din, 8'h00);
    rd_cyc(32'h0003_0007);
    check("cc_b3", bus.mem_din, 8'h00);
`endif

    // prog_done, then mid-stream reset
    wr_cyc(32'h0003_0004, 8'h77);
    check("pd_set", bus.prog_done, 1);
    check("pd_txv", bus.tx_valid, 1);
    check("pd_tx0", bus.tx_data, 8'h00);
    rd_cyc(32'h0000_0010);
    check("pd_sticky", bus.prog_done, 1);
    #2 rst_in = 1'b0;
    #1;
    check("mr_done", bus.prog_done, 0);
    check("mr_txv", bus.tx_valid, 0);
    check("mr_din", bus.mem_din, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    rd_cyc(32'h0000_0010);
    check("mr_ram", bus.mem_din, 8'hA5);
    check("mr_txv2", bus.tx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
